// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the I/D memory arbiter: FSM states, grant IDs and tie-break helper.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned MAX_WAIT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_I  = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // With rr_en clear, D wins every tie; otherwise the port not granted last time wins.
  function automatic logic pick_d(logic i_req, logic d_req, grant_e last_grant, logic rr_en);
    return d_req & (~i_req | ~rr_en | (last_grant == GNT_I));
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-system signals around the arbiter.
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              i_rd;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data_out;
  logic              i_done;
  logic              i_stall;
  logic              i_hit;

  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_data_in;
  logic [DATA_W-1:0] d_data_out;
  logic              d_done;
  logic              d_stall;
  logic              d_hit;

  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data_in;
  logic              m_rd;
  logic              m_wr;
  logic [DATA_W-1:0] m_data_out;
  logic              m_done;
  logic              m_hit;

  // Arbiter side.
  modport slave (
    input  i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in, m_data_out, m_done, m_hit,
    output i_data_out, i_done, i_stall, i_hit, d_data_out, d_done, d_stall, d_hit,
           m_addr, m_data_in, m_rd, m_wr
  );

  // Requesters plus memory system.
  modport master (
    output i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in, m_data_out, m_done, m_hit,
    input  i_data_out, i_done, i_stall, i_hit, d_data_out, d_done, d_stall, d_hit,
           m_addr, m_data_in, m_rd, m_wr
  );
endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Saturating busy-cycle counter; timeout_o asserts in the cycle the count reaches MAX_WAIT.
module mem_arb_watchdog #(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic timeout_o
);
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign timeout_o = en_i & ~clear_i & (cnt_d == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single memory system with hold registers and watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority with D over I.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          err
);
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  arb_state_e        state_q;
  grant_e            last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic [DATA_W-1:0] i_data_q;
  logic [DATA_W-1:0] d_data_q;
  logic              i_done_q;
  logic              d_done_q;
  logic              i_hit_q;
  logic              d_hit_q;
  logic              err_q;

  logic i_req;
  logic d_req;
  logic grant_any;
  logic grant_d;
  logic busy;
  logic illegal;
  logic wd_timeout;

  always_comb begin
    i_req     = bus.i_rd;
    d_req     = bus.d_rd | bus.d_wr;
    grant_any = (state_q == ST_IDLE) & (i_req | d_req);
    grant_d   = pick_d(i_req, d_req, last_grant_q, RR_EN);
    busy      = (state_q == ST_BUSY_I) | (state_q == ST_BUSY_D);
    illegal   = grant_any & grant_d & bus.d_rd & bus.d_wr;
  end

  mem_arb_watchdog #(.MAX_WAIT(MAX_WAIT)) u_wd (
    .clk       (clk),
    .rst_n     (rst),
    .clear_i   (grant_any),
    .en_i      (busy),
    .timeout_o (wd_timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      i_data_q     <= '0;
      d_data_q     <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_hit_q      <= 1'b0;
      d_hit_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      if (illegal || (busy && wd_timeout && !bus.m_done)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            if (grant_d) begin
              state_q      <= ST_BUSY_D;
              last_grant_q <= GNT_D;
              addr_q       <= bus.d_addr;
              wdata_q      <= bus.d_data_in;
              rd_q         <= bus.d_rd;
              // Read+write together is demoted to a plain read.
              wr_q         <= bus.d_wr & ~bus.d_rd;
            end else begin
              state_q      <= ST_BUSY_I;
              last_grant_q <= GNT_I;
              addr_q       <= bus.i_addr;
              rd_q         <= 1'b1;
              wr_q         <= 1'b0;
            end
          end
        end
        ST_BUSY_I: begin
          if (bus.m_done) begin
            i_data_q <= bus.m_data_out;
            i_hit_q  <= bus.m_hit;
            i_done_q <= 1'b1;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            state_q  <= ST_RELEASE;
          end
        end
        ST_BUSY_D: begin
          if (bus.m_done) begin
            d_data_q <= bus.m_data_out;
            d_hit_q  <= bus.m_hit;
            d_done_q <= 1'b1;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            state_q  <= ST_RELEASE;
          end
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_addr     = addr_q;
  assign bus.m_data_in  = wdata_q;
  assign bus.m_rd       = rd_q;
  assign bus.m_wr       = wr_q;
  assign bus.i_data_out = i_data_q;
  assign bus.i_done     = i_done_q;
  assign bus.i_hit      = i_hit_q;
  assign bus.d_data_out = d_data_q;
  assign bus.d_done     = d_done_q;
  assign bus.d_hit      = d_hit_q;
  // Stall is qualified by reset so it drops in the same cycle reset is applied.
  assign bus.i_stall    = rst & i_req & ~i_done_q;
  assign bus.d_stall    = rst & d_req & ~d_done_q;
  assign err            = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions, a monitor pops them on x_done.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port_d;
    logic [15:0] data;
    logic        hit;
  } exp_t;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && (bus.i_done || bus.d_done)) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'({bus.i_done, bus.d_done}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_port", 32'({bus.i_done, bus.d_done}), e.port_d ? 32'd1 : 32'd2);
        check("done_data", 32'(e.port_d ? bus.d_data_out : bus.i_data_out), 32'(e.data));
        check("done_hit", 32'(e.port_d ? bus.d_hit : bus.i_hit), 32'(e.hit));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_rd = 1'b0; bus.i_addr = '0;
    bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_data_in = '0;
    bus.m_data_out = '0; bus.m_done = 1'b0; bus.m_hit = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_grant(output int unsigned cycles);
    bit ok = 1'b0;
    cycles = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      cycles++;
      if (bus.m_rd || bus.m_wr) begin
        ok = 1'b1;
        break;
      end
    end
    check("grant_seen", 32'(ok), 32'd1);
  endtask

  // Entered one step after the grant edge; checks the held command every BUSY cycle, completes after L cycles.
  task automatic serve(input logic exp_rd, input logic exp_wr, input logic [15:0] exp_addr,
                       input logic [15:0] exp_wdata, input logic [15:0] rdata,
                       input logic hit, input int unsigned L);
    for (int unsigned c = 0; c < L; c++) begin
      check("busy_m_rd", 32'(bus.m_rd), 32'(exp_rd));
      check("busy_m_wr", 32'(bus.m_wr), 32'(exp_wr));
      check("busy_m_addr", 32'(bus.m_addr), 32'(exp_addr));
      if (exp_wr) check("busy_m_data_in", 32'(bus.m_data_in), 32'(exp_wdata));
      if (c == L - 1) begin
        bus.m_done = 1'b1; bus.m_data_out = rdata; bus.m_hit = hit;
      end
      tick();
    end
    bus.m_done = 1'b0; bus.m_data_out = '0; bus.m_hit = 1'b0;
    check("release_m_rd", 32'(bus.m_rd), 32'd0);
    check("release_m_wr", 32'(bus.m_wr), 32'd0);
  endtask

  initial begin : global_limit
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : stim
    int unsigned lat;
    logic        pd;
    clear_inputs();
    #1;
    do_reset();

    // Reset state
    check("rst_m_rd", 32'(bus.m_rd), 32'd0);
    check("rst_m_wr", 32'(bus.m_wr), 32'd0);
    check("rst_m_addr", 32'(bus.m_addr), 32'd0);
    check("rst_i_data", 32'(bus.i_data_out), 32'd0);
    check("rst_done", 32'({bus.i_done, bus.d_done}), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Single fetch
    sb.push_back('{1'b0, 16'hBEEF, 1'b1});
    bus.i_rd = 1'b1; bus.i_addr = 16'h1234;
    #1;
    check("fetch_stall", 32'(bus.i_stall), 32'd1);
    check("fetch_pre_m_rd", 32'(bus.m_rd), 32'd0);
    wait_grant(lat);
    check("fetch_latency", lat, 32'd1);
    serve(1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 1'b1, 1);
    check("fetch_done_stall", 32'(bus.i_stall), 32'd0);
    bus.i_rd = 1'b0;
    tick();
    check("fetch_done_once", 32'(bus.i_done), 32'd0);
    check("fetch_data_hold", 32'(bus.i_data_out), 32'hBEEF);

    // Write hold over a 10-cycle miss
    sb.push_back('{1'b1, 16'h0000, 1'b0});
    bus.d_wr = 1'b1; bus.d_addr = 16'h0040; bus.d_data_in = 16'h5A5A;
    wait_grant(lat);
    serve(1'b0, 1'b1, 16'h0040, 16'h5A5A, 16'h0000, 1'b0, 10);
    bus.d_wr = 1'b0;
    tick();

    // Ties with both requests held across four grants
    do_reset();
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      pd = (k % 2 == 0);
`else
      pd = 1'b1;
`endif
      sb.push_back('{pd, 16'hA000 + 16'(k), 1'(k % 2)});
    end
    bus.i_rd = 1'b1; bus.i_addr = 16'h1000;
    bus.d_rd = 1'b1; bus.d_addr = 16'h2000;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      pd = (k % 2 == 0);
`else
      pd = 1'b1;
`endif
      wait_grant(lat);
      serve(1'b1, 1'b0, pd ? 16'h2000 : 16'h1000, 16'h0000, 16'hA000 + 16'(k), 1'(k % 2), 2);
      if (k == 3) begin
        bus.i_rd = 1'b0; bus.d_rd = 1'b0;
      end
    end
    tick();

    // Reset in the middle of a data transaction
    do_reset();
    bus.d_rd = 1'b1; bus.d_addr = 16'h0300;
    wait_grant(lat);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("midrst_m_rd", 32'(bus.m_rd), 32'd0);
    check("midrst_d_done", 32'(bus.d_done), 32'd0);
    check("midrst_d_stall", 32'(bus.d_stall), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    bus.d_rd = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    sb.push_back('{1'b0, 16'h4444, 1'b0});
    bus.i_rd = 1'b1; bus.i_addr = 16'h0400;
    wait_grant(lat);
    check("midrst_idle_latency", lat, 32'd1);
    serve(1'b1, 1'b0, 16'h0400, 16'h0000, 16'h4444, 1'b0, 1);
    bus.i_rd = 1'b0;
    tick();

    // Watchdog
    do_reset();
    sb.push_back('{1'b0, 16'h7777, 1'b0});
    bus.i_rd = 1'b1; bus.i_addr = 16'h0500;
    wait_grant(lat);
    repeat (7) tick();
    check("wd_err_before", 32'(err), 32'd0);
    tick();
    check("wd_err_rise", 32'(err), 32'd1);
    repeat (5) tick();
    check("wd_err_held", 32'(err), 32'd1);
    serve(1'b1, 1'b0, 16'h0500, 16'h0000, 16'h7777, 1'b0, 2);
    bus.i_rd = 1'b0;
    tick();
    check("wd_err_sticky", 32'(err), 32'd1);

    // Illegal read+write command
    do_reset();
    sb.push_back('{1'b1, 16'h3C3C, 1'b1});
    bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0700; bus.d_data_in = 16'h1111;
    wait_grant(lat);
    check("illegal_err", 32'(err), 32'd1);
    serve(1'b1, 1'b0, 16'h0700, 16'h0000, 16'h3C3C, 1'b1, 2);
    bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    repeat (3) tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
